// File: rtl/hack_fetch_pc_pkg.sv
// Shared constants and FSM state encoding for the Hack CPU fetch stage.
package hack_fetch_pc_pkg;

  // Only 16 is supported: the incrementer is fixed at 16 bits.
  localparam int                      FETCH_WIDTH      = 16;
  localparam logic [FETCH_WIDTH-1:0]  FETCH_RESET_ADDR = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DRAIN   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/hack_fetch_pc_inc16.sv
// Hack-style 16-bit incrementer: a ripple chain of half adders, out = in + 1 mod 2^16.
module Inc16 (
  input  logic [15:0] i_a,
  output logic [15:0] o_sum
);

  logic [15:0] w_carry;

  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < 16; g++) begin : g_half_add
    assign o_sum[g] = i_a[g] ^ w_carry[g];
    // The carry out of bit 15 is dropped: FFFF wraps to 0000.
    if (g < 15) begin : g_carry
      assign w_carry[g+1] = i_a[g] & w_carry[g];
    end
  end

endmodule

// File: rtl/hack_fetch_pc.sv
// Hack CPU program counter and instruction fetch: ROM req/ack on one side,
// instruction valid/ready toward decode on the other, jump targets taken back.
module hack_fetch_pc
  import hack_fetch_pc_pkg::*;
#(
  parameter int                     WIDTH      = FETCH_WIDTH,
  parameter logic [WIDTH-1:0]       RESET_ADDR = FETCH_RESET_ADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  output logic             rom_req,
  output logic [WIDTH-1:0] rom_addr,
  input  logic             rom_ack,
  input  logic [WIDTH-1:0] rom_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] pc,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_addr
);

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [WIDTH-1:0] r_fetch_addr;
  logic [WIDTH-1:0] w_fetch_addr_nxt;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_inc;
  logic             w_load_instr;

  Inc16 u_inc16 (
    .i_a   (r_pc),
    .o_sum (w_pc_inc)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_addr_nxt = r_fetch_addr;
    w_load_instr     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_state_nxt      = ST_FETCH;
        w_fetch_addr_nxt = RESET_ADDR;
      end
      ST_FETCH: begin
        if (restart) begin
          // An outstanding request cannot be withdrawn; wait it out in DRAIN.
          if (rom_ack) begin
            w_state_nxt      = ST_FETCH;
            w_fetch_addr_nxt = RESET_ADDR;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end else if (rom_ack) begin
          w_state_nxt  = ST_PRESENT;
          w_load_instr = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (restart) begin
          w_state_nxt      = ST_FETCH;
          w_fetch_addr_nxt = RESET_ADDR;
        end else if (instr_ready) begin
          w_state_nxt      = ST_FETCH;
          w_fetch_addr_nxt = jump ? jump_addr : w_pc_inc;
        end
      end
      ST_DRAIN: begin
        if (rom_ack) begin
          w_state_nxt      = ST_FETCH;
          w_fetch_addr_nxt = RESET_ADDR;
        end
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_fetch_addr_nxt = RESET_ADDR;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_fetch_addr <= RESET_ADDR;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
    end
  end

  // NOTE: the instruction/pc holding registers are reset too, so decode never
  // sees stale data after reset even though instr_valid already gates them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= '0;
      r_pc    <= '0;
    end else if (w_load_instr) begin
      r_instr <= rom_data;
      r_pc    <= r_fetch_addr;
    end
  end

  assign rom_req     = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign rom_addr    = r_fetch_addr;
  assign instr_valid = (r_state == ST_PRESENT);
  assign instr       = r_instr;
  assign pc          = r_pc;

  // Protocol invariants: a pending request and a held instruction stay put.
  a_req_stable : assert property (@(posedge clk) disable iff (reset)
    (rom_req && !rom_ack) |=> (rom_req && $stable(rom_addr)));

  a_instr_stable : assert property (@(posedge clk) disable iff (reset)
    (instr_valid && !instr_ready && !restart) |=>
      (instr_valid && $stable(instr) && $stable(pc)));

endmodule

// File: tb/tb_hack_fetch_pc.sv
// Scoreboard bench for hack_fetch_pc: expected (pc, instr) pairs are queued as
// fetch targets are decided and compared while the DUT presents instructions.
module tb_hack_fetch_pc;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        restart;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        jump;
  logic [15:0] jump_addr;

  always #5 clk = ~clk;

  hack_fetch_pc dut (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_ack     (rom_ack),
    .rom_data    (rom_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc          (pc),
    .jump        (jump),
    .jump_addr   (jump_addr)
  );

  int          n_tests = 0;
  int          n_fail  = 0;

  exp_t        exp_q[$];
  logic [15:0] m_fetch;
  bit          m_drain;
  int          wait_left;
  int          rom_wait;

  bit          fetch_noise;
  bit          jump_en;
  logic [15:0] jump_pc;
  logic [15:0] jump_tgt;
  logic [15:0] stall_pc;
  int          stall_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] a);
    return {a, a ^ 16'hA5A5};
  endfunction

  task automatic model_restart();
    exp_q.delete();
    m_fetch = 16'h0000;
    m_drain = 1'b0;
    exp_q.push_back(mk(16'h0000));
  endtask

  // One clock: ROM responds, model advances on pre-edge values, outputs checked after.
  task automatic tick();
    bit          hs;
    bit          ack;
    exp_t        front;
    logic [15:0] nxt;
    if (rom_req) begin
      if (wait_left == 0) begin
        rom_ack  = 1'b1;
        rom_data = rom_addr ^ 16'hA5A5;
      end else begin
        rom_ack  = 1'b0;
        rom_data = 16'hBEEF;
        wait_left--;
      end
    end else begin
      rom_ack  = 1'b1;       // stray ack with no request must be ignored
      rom_data = 16'hDEAD;
    end
    hs  = instr_valid && instr_ready;
    ack = rom_req && rom_ack;
    if (restart && !m_drain) begin
      if (rom_req && !ack) begin
        m_drain = 1'b1;
        exp_q.delete();
      end else begin
        model_restart();
      end
    end else if (m_drain) begin
      if (ack) model_restart();
    end else if (hs) begin
      if (exp_q.size() == 0) begin
        check("hs_with_empty_queue", {31'b0, hs}, 32'd0);
      end else begin
        front   = exp_q.pop_front();
        nxt     = jump ? jump_addr : front.pc + 16'd1;
        m_fetch = nxt;
        exp_q.push_back(mk(nxt));
      end
    end
    @(posedge clk);
    if (ack) wait_left = rom_wait;
    #1;
    if (rom_req) check("rom_addr", {16'b0, rom_addr}, {16'b0, m_fetch});
    if (m_drain) check("valid_in_drain", {31'b0, instr_valid}, 32'd0);
    if (instr_valid) begin
      check("rom_req_in_present", {31'b0, rom_req}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {31'b0, instr_valid}, 32'd0);
      end else begin
        check("pc", {16'b0, pc}, {16'b0, exp_q[0].pc});
        check("instr", {16'b0, instr}, {16'b0, exp_q[0].instr});
      end
    end
  endtask

  task automatic set_inputs();
    jump        = 1'b0;
    jump_addr   = 16'h0000;
    instr_ready = 1'b1;
    if (!instr_valid && fetch_noise) begin
      jump      = 1'b1;
      jump_addr = 16'h1234;
    end
    if (instr_valid && exp_q.size() > 0) begin
      if (jump_en && exp_q[0].pc == jump_pc) begin
        jump      = 1'b1;
        jump_addr = jump_tgt;
      end
      if (exp_q[0].pc == stall_pc && stall_left > 0) begin
        instr_ready = 1'b0;
        jump        = 1'b1;
        jump_addr   = 16'h7777;
        stall_left--;
      end
    end
  endtask

  task automatic run_until(input string tag, input logic [15:0] tgt, input int budget);
    bit reached = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (instr_valid && exp_q.size() > 0 && exp_q[0].pc == tgt) begin
        reached = 1'b1;
        break;
      end
      set_inputs();
      tick();
    end
    if (!reached && instr_valid && exp_q.size() > 0 && exp_q[0].pc == tgt) reached = 1'b1;
    check(tag, {31'b0, reached}, 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    restart     = 1'b0;
    rom_ack     = 1'b0;
    rom_data    = 16'h0000;
    instr_ready = 1'b1;
    jump        = 1'b0;
    jump_addr   = 16'h0000;
    rom_wait    = 0;
    wait_left   = 0;
    fetch_noise = 1'b0;
    jump_en     = 1'b0;
    jump_pc     = 16'h0000;
    jump_tgt    = 16'h0000;
    stall_pc    = 16'h0000;
    stall_left  = 0;
    m_fetch     = 16'h0000;
    m_drain     = 1'b0;

    #2;
    check("rst_rom_req", {31'b0, rom_req}, 32'd0);
    check("rst_rom_addr", {16'b0, rom_addr}, 32'h0000);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", {16'b0, instr}, 32'h0000);
    check("rst_pc", {16'b0, pc}, 32'h0000);

    // Zero-wait ROM: first request at 0, one instruction every 2 cycles.
    @(negedge clk);
    reset = 1'b0;
    model_restart();
    set_inputs();
    tick();
    check("first_req", {31'b0, rom_req}, 32'd1);
    check("first_addr", {16'b0, rom_addr}, 32'h0000);
    run_until("reach_pc0", 16'h0000, 10);
    for (int k = 1; k <= 4; k++) begin
      set_inputs();
      tick();
      check("throughput", {31'b0, instr_valid}, {31'b0, (k % 2 == 0)});
    end

    // Jump at pc=3 to 0x0100, with spurious jump during FETCH cycles.
    fetch_noise = 1'b1;
    jump_en     = 1'b1;
    jump_pc     = 16'h0003;
    jump_tgt    = 16'h0100;
    run_until("reach_pc3", 16'h0003, 10);
    set_inputs();
    tick();
    check("jump_addr", {16'b0, rom_addr}, 32'h0100);
    run_until("reach_pc100", 16'h0100, 10);

    // Backpressure at pc=5 for 5 cycles.
    jump_pc  = 16'h0100;
    jump_tgt = 16'h0005;
    run_until("reach_pc5", 16'h0005, 10);
    stall_pc   = 16'h0005;
    stall_left = 5;
    for (int k = 0; k < 5; k++) begin
      set_inputs();
      tick();
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_pc", {16'b0, pc}, 32'h0005);
    end
    set_inputs();
    tick();
    check("after_stall_addr", {16'b0, rom_addr}, 32'h0006);

    // Wrap-around from 0xFFFF.
    jump_pc  = 16'h0006;
    jump_tgt = 16'hFFFF;
    run_until("reach_pcFFFF", 16'hFFFF, 10);
    jump_en = 1'b0;
    set_inputs();
    tick();
    check("wrap_addr", {16'b0, rom_addr}, 32'h0000);
    run_until("reach_wrap0", 16'h0000, 10);
    check("wrap_pc", {16'b0, pc}, 32'h0000);

    // Restart in the first wait cycle of a 3-wait fetch at 0x0040.
    fetch_noise = 1'b0;
    jump_en     = 1'b1;
    jump_pc     = 16'h0000;
    jump_tgt    = 16'h0040;
    set_inputs();
    wait_left = 3;
    rom_wait  = 0;
    tick();
    jump_en = 1'b0;
    check("slow_fetch_addr", {16'b0, rom_addr}, 32'h0040);
    set_inputs();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("drain_addr", {16'b0, rom_addr}, 32'h0040);
    check("drain_req", {31'b0, rom_req}, 32'd1);
    run_until("reach_restart0", 16'h0000, 12);

    // Restart while presenting.
    set_inputs();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("rs_present_valid", {31'b0, instr_valid}, 32'd0);
    check("rs_present_addr", {16'b0, rom_addr}, 32'h0000);
    run_until("reach_after_rs", 16'h0001, 10);

    // Asynchronous reset between edges while presenting pc=1.
    #3;
    reset = 1'b1;
    #1;
    check("arst_valid", {31'b0, instr_valid}, 32'd0);
    check("arst_req", {31'b0, rom_req}, 32'd0);
    check("arst_instr", {16'b0, instr}, 32'h0000);
    check("arst_pc", {16'b0, pc}, 32'h0000);
    @(negedge clk);
    reset = 1'b0;
    model_restart();
    set_inputs();
    tick();
    check("arst_refetch", {16'b0, rom_addr}, 32'h0000);
    run_until("reach_after_arst", 16'h0002, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
